// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage core.
// Shadows each in-flight writer through E/M/W, ages its Tnew as it advances,
// and derives the D stall plus the forwarding selects for D, E and M.
// The rs/rt use bits are consumed in D only. Stalls are decided there, and
// forwarding deliberately ignores use bits, so they are not carried into E/M.
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_A1,
  input  logic [4:0] D_A2,
  input  logic [4:0] D_A3,
  input  logic       D_rs_use,
  input  logic       D_rt_use,
  input  logic [2:0] D_rsTuse,
  input  logic [2:0] D_rtTuse,
  input  logic [2:0] D_Tnew,
  output logic       stall,
  output logic [1:0] D_fwd_rs,
  output logic [1:0] D_fwd_rt,
  output logic [1:0] E_fwd_rs,
  output logic [1:0] E_fwd_rt,
  output logic [1:0] M_fwd_rt,
  output logic [2:0] E_Tnew_q,
  output logic [2:0] M_Tnew_q
);

  logic [4:0] e_a1, e_a2, e_a3;
  logic [2:0] e_tnew;
  logic [4:0] m_a2, m_a3;
  logic [2:0] m_tnew;
  logic [4:0] w_a3;

  logic       rs_hz, rt_hz;

  function automatic logic [2:0] sat_dec(input logic [2:0] x);
    return (x != 3'd0) ? (x - 3'd1) : 3'd0;
  endfunction

  // One producer stage in a nearest-first forwarding chain: a match on this
  // stage decides the select (its code if ready, else none); otherwise the
  // decision falls through to the older stage.
  function automatic logic [1:0] pick(input logic [4:0] r,
                                      input logic [4:0] a3,
                                      input logic [2:0] tnew,
                                      input logic [1:0] code,
                                      input logic [1:0] older);
    if (r != 5'd0 && a3 == r)
      return (tnew == 3'd0) ? code : 2'd0;
    return older;
  endfunction

  // Operand hazard: the youngest matching producer in E or M decides.
  function automatic logic op_hz(input logic       use_op,
                                 input logic [4:0] r,
                                 input logic [2:0] tuse,
                                 input logic [4:0] ea3,
                                 input logic [2:0] etnew,
                                 input logic [4:0] ma3,
                                 input logic [2:0] mtnew);
    if (!use_op || r == 5'd0)
      return 1'b0;
    if (ea3 == r)
      return etnew > tuse;
    if (ma3 == r)
      return mtnew > tuse;
    return 1'b0;
  endfunction

  // Shadow pipeline: E loads D (or a bubble on stall), M and W always advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_a1   <= 5'd0;
      e_a2   <= 5'd0;
      e_a3   <= 5'd0;
      e_tnew <= 3'd0;
      m_a2   <= 5'd0;
      m_a3   <= 5'd0;
      m_tnew <= 3'd0;
      w_a3   <= 5'd0;
    end else begin
      if (stall) begin
        e_a1   <= 5'd0;
        e_a2   <= 5'd0;
        e_a3   <= 5'd0;
        e_tnew <= 3'd0;
      end else begin
        e_a1   <= D_A1;
        e_a2   <= D_A2;
        e_a3   <= D_A3;
        e_tnew <= D_Tnew;
      end
      m_a2   <= e_a2;
      m_a3   <= e_a3;
      m_tnew <= sat_dec(e_tnew);
      w_a3   <= m_a3;
    end
  end

  // Stall D whenever an operand is needed before its producer can supply it.
  always_comb begin
    rs_hz = op_hz(D_rs_use, D_A1, D_rsTuse, e_a3, e_tnew, m_a3, m_tnew);
    rt_hz = op_hz(D_rt_use, D_A2, D_rtTuse, e_a3, e_tnew, m_a3, m_tnew);
    stall = rs_hz | rt_hz;
  end

  // Forward selects: scan producers nearest first; W results are always ready.
  always_comb begin
    D_fwd_rs = pick(D_A1, e_a3, e_tnew, 2'd1,
               pick(D_A1, m_a3, m_tnew, 2'd2,
               pick(D_A1, w_a3, 3'd0,   2'd3, 2'd0)));
    D_fwd_rt = pick(D_A2, e_a3, e_tnew, 2'd1,
               pick(D_A2, m_a3, m_tnew, 2'd2,
               pick(D_A2, w_a3, 3'd0,   2'd3, 2'd0)));
    E_fwd_rs = pick(e_a1, m_a3, m_tnew, 2'd2,
               pick(e_a1, w_a3, 3'd0,   2'd3, 2'd0));
    E_fwd_rt = pick(e_a2, m_a3, m_tnew, 2'd2,
               pick(e_a2, w_a3, 3'd0,   2'd3, 2'd0));
    M_fwd_rt = pick(m_a2, w_a3, 3'd0,   2'd3, 2'd0);
  end

  // Tracked Tnew exposed for debug.
  always_comb begin
    E_Tnew_q = e_tnew;
    M_Tnew_q = m_tnew;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios followed by a randomized
// instruction stream, all checked against an in-flight instruction model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_A1, D_A2, D_A3;
  logic       D_rs_use, D_rt_use;
  logic [2:0] D_rsTuse, D_rtTuse, D_Tnew;
  logic       stall;
  logic [1:0] D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, M_fwd_rt;
  logic [2:0] E_Tnew_q, M_Tnew_q;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .D_A1(D_A1), .D_A2(D_A2), .D_A3(D_A3),
    .D_rs_use(D_rs_use), .D_rt_use(D_rt_use),
    .D_rsTuse(D_rsTuse), .D_rtTuse(D_rtTuse), .D_Tnew(D_Tnew),
    .stall(stall),
    .D_fwd_rs(D_fwd_rs), .D_fwd_rt(D_fwd_rt),
    .E_fwd_rs(E_fwd_rs), .E_fwd_rt(E_fwd_rt), .M_fwd_rt(M_fwd_rt),
    .E_Tnew_q(E_Tnew_q), .M_Tnew_q(M_Tnew_q)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: slot 1/2/3 = instruction sitting in E/M/W, with its issue-time Tnew.
  bit         sv  [1:3];
  logic [4:0] sa1 [1:3];
  logic [4:0] sa2 [1:3];
  logic [4:0] sa3 [1:3];
  int         st0 [1:3];

  logic       last_stall;
  logic [1:0] last_dfrs, last_dfrt;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Remaining cycles until the slot's result exists; W results are always ready.
  function automatic int eff(input int k);
    int left;
    if (k == 3) return 0;
    left = st0[k] - (k - 1);
    return (left > 0) ? left : 0;
  endfunction

  function automatic logic [1:0] scan(input logic [4:0] r, input int first);
    for (int k = first; k <= 3; k++)
      if (r != 5'd0 && sa3[k] == r)
        return (eff(k) == 0) ? 2'(k) : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic hz(input logic u, input logic [4:0] r, input logic [2:0] tuse);
    if (!u || r == 5'd0) return 1'b0;
    for (int k = 1; k <= 2; k++)
      if (sa3[k] == r) return eff(k) > int'(tuse);
    return 1'b0;
  endfunction

  function automatic logic exp_stall();
    return hz(D_rs_use, D_A1, D_rsTuse) | hz(D_rt_use, D_A2, D_rtTuse);
  endfunction

  task automatic model_reset();
    for (int k = 1; k <= 3; k++) begin
      sv[k] = 1'b0; sa1[k] = 5'd0; sa2[k] = 5'd0; sa3[k] = 5'd0; st0[k] = 0;
    end
  endtask

  task automatic model_edge(input logic stl);
    for (int k = 3; k >= 2; k--) begin
      sv[k] = sv[k-1]; sa1[k] = sa1[k-1]; sa2[k] = sa2[k-1];
      sa3[k] = sa3[k-1]; st0[k] = st0[k-1];
    end
    if (stl) begin
      sv[1] = 1'b0; sa1[1] = 5'd0; sa2[1] = 5'd0; sa3[1] = 5'd0; st0[1] = 0;
    end else begin
      sv[1] = 1'b1; sa1[1] = D_A1; sa2[1] = D_A2; sa3[1] = D_A3; st0[1] = int'(D_Tnew);
    end
  endtask

  // E/M operand selects of a bubble are don't-care, so only real occupants are checked.
  task automatic check_all();
    check("stall",    {7'd0, stall},   {7'd0, exp_stall()});
    check("D_fwd_rs", {6'd0, D_fwd_rs}, {6'd0, scan(D_A1, 1)});
    check("D_fwd_rt", {6'd0, D_fwd_rt}, {6'd0, scan(D_A2, 1)});
    if (sv[1]) begin
      check("E_fwd_rs", {6'd0, E_fwd_rs}, {6'd0, scan(sa1[1], 2)});
      check("E_fwd_rt", {6'd0, E_fwd_rt}, {6'd0, scan(sa2[1], 2)});
    end
    if (sv[2])
      check("M_fwd_rt", {6'd0, M_fwd_rt}, {6'd0, scan(sa2[2], 3)});
    check("E_Tnew_q", {5'd0, E_Tnew_q}, 8'(eff(1)));
    check("M_Tnew_q", {5'd0, M_Tnew_q}, 8'(eff(2)));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, {7'd0, stall}, 8'd0);
    check({tag, "_fwd"}, {D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt}, 8'd0);
    check({tag, "_mfwd"}, {6'd0, M_fwd_rt}, 8'd0);
    check({tag, "_tnew"}, {2'd0, E_Tnew_q, M_Tnew_q}, 8'd0);
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                       input logic ru, input logic tu, input logic [2:0] rst,
                       input logic [2:0] rtt, input logic [2:0] tn);
    D_A1 = a1; D_A2 = a2; D_A3 = a3; D_rs_use = ru; D_rt_use = tu;
    D_rsTuse = rst; D_rtTuse = rtt; D_Tnew = tn;
  endtask

  // Hold the descriptor in D until the DUT stops stalling; returns stall cycles.
  task automatic issue(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                       input logic ru, input logic tu, input logic [2:0] rst,
                       input logic [2:0] rtt, input logic [2:0] tn, output int nstall);
    logic s_exp;
    logic s_dut;
    nstall = 0;
    drive(a1, a2, a3, ru, tu, rst, rtt, tn);
    for (int i = 0; i < 8; i++) begin
      #2;
      check_all();
      s_exp = exp_stall();
      s_dut = stall;
      last_stall = stall; last_dfrs = D_fwd_rs; last_dfrt = D_fwd_rt;
      if (s_dut === 1'b1) nstall++;
      @(posedge clk); #1;
      model_edge(s_exp);
      if (s_dut !== 1'b1) return;
    end
    n_cmp++; n_fail++;
    $error("FAIL issue_timeout stall_cycles=%0d limit=8", nstall);
  endtask

  int ns;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_zero("reset");
    reset = 1'b0;

    // lw $8 ; addu $9,$8,$1 -> one stall, then E forwards rs from W
    issue(5'd29, 5'd0, 5'd8, 1, 0, 3'd1, 3'd0, 3'd2, ns);
    issue(5'd8, 5'd1, 5'd9, 1, 1, 3'd1, 3'd1, 3'd1, ns);
    check("lw_addu_stalls", 8'(ns), 8'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("lw_addu_E_fwd_rs", {6'd0, E_fwd_rs}, 8'd3);
    issue(0, 0, 0, 0, 0, 0, 0, 0, ns);
    issue(0, 0, 0, 0, 0, 0, 0, 0, ns);

    // lw $8 ; beq $8,$0 -> two stalls, then D forwards rs from W
    issue(5'd29, 5'd0, 5'd8, 1, 0, 3'd1, 3'd0, 3'd2, ns);
    issue(5'd8, 5'd0, 5'd0, 1, 1, 3'd0, 3'd0, 3'd0, ns);
    check("lw_beq_stalls", 8'(ns), 8'd2);
    check("lw_beq_D_fwd_rs", {6'd0, last_dfrs}, 8'd3);
    issue(0, 0, 0, 0, 0, 0, 0, 0, ns);

    // addu $4 ; sw $4,0($5) -> no stall, E then M forward the store data
    issue(5'd1, 5'd2, 5'd4, 1, 1, 3'd1, 3'd1, 3'd1, ns);
    issue(5'd5, 5'd4, 5'd0, 1, 1, 3'd1, 3'd2, 3'd0, ns);
    check("addu_sw_stalls", 8'(ns), 8'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("addu_sw_E_fwd_rt", {6'd0, E_fwd_rt}, 8'd2);
    issue(0, 0, 0, 0, 0, 0, 0, 0, ns);
    drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("addu_sw_M_fwd_rt", {6'd0, M_fwd_rt}, 8'd3);

    // lui $2 ; addu $3,$2,$2 -> no stall, both D operands from E
    issue(5'd0, 5'd0, 5'd2, 0, 0, 3'd0, 3'd0, 3'd0, ns);
    issue(5'd2, 5'd2, 5'd3, 1, 1, 3'd1, 3'd1, 3'd1, ns);
    check("lui_addu_stalls", 8'(ns), 8'd0);
    check("lui_addu_D_fwd", {4'd0, last_dfrs, last_dfrt}, 8'h05);

    // lw $0 ; addu using $0 -> never stalls or forwards
    issue(5'd29, 5'd0, 5'd0, 1, 0, 3'd1, 3'd0, 3'd2, ns);
    issue(5'd0, 5'd0, 5'd9, 1, 1, 3'd0, 3'd0, 3'd1, ns);
    check("lw_r0_stalls", 8'(ns), 8'd0);
    check("lw_r0_D_fwd", {4'd0, last_dfrs, last_dfrt}, 8'd0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, ns);
    issue(0, 0, 0, 0, 0, 0, 0, 0, ns);

    // Reset asserted in the middle of a lw/beq stall
    issue(5'd29, 5'd0, 5'd8, 1, 0, 3'd1, 3'd0, 3'd2, ns);
    drive(5'd8, 5'd0, 5'd0, 1, 1, 3'd0, 3'd0, 3'd0); #2;
    check("midstall_stall", {7'd0, stall}, 8'd1);
    reset = 1'b1; #1;
    model_reset();
    check_zero("async_reset");
    @(posedge clk); #1;
    check_zero("reset_held");
    reset = 1'b0;
    issue(5'd3, 5'd4, 5'd7, 1, 1, 3'd1, 3'd1, 3'd2, ns);
    check("post_reset_E_Tnew", {5'd0, E_Tnew_q}, 8'd2);
    issue(0, 0, 0, 0, 0, 0, 0, 0, ns);
    check("post_reset_M_Tnew", {5'd0, M_Tnew_q}, 8'd1);

    // Random instruction stream over a small register set to force collisions
    for (int i = 0; i < 400; i++) begin
      issue(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            3'($urandom_range(0, 2)), ns);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
